// File: rtl/exu_oitf_pkg.sv
// Shared types and constants for the outstanding instruction track FIFO.
// Holds the default depth, the register index width and the x0 index.
package exu_oitf_pkg;

  localparam int OITF_DEPTH_DEF = 4;
  localparam int REG_IDX_W      = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t X0_IDX = '0;

  typedef struct packed {
    logic     valid;
    logic     rdwen;
    reg_idx_t rd_idx;
  } oitf_entry_t;

endpackage

// File: rtl/exu_oitf_if.sv
// Dispatch / retire bundle between issue logic (master) and the OITF (slave).
interface exu_oitf_if #(
  parameter int PTR_W = 2
);
  import exu_oitf_pkg::*;

  logic             disp_valid_i;
  logic             disp_ready_o;
  logic             disp_longp_i;
  logic             disp_rs1en_i;
  logic             disp_rs2en_i;
  logic             disp_rdwen_i;
  reg_idx_t         disp_rs1_idx_i;
  reg_idx_t         disp_rs2_idx_i;
  reg_idx_t         disp_rd_idx_i;
  logic [PTR_W-1:0] alc_ptr_o;

  logic             ret_valid_i;
  logic             ret_ready_o;
  logic [PTR_W-1:0] ret_ptr_o;
  logic             ret_rdwen_o;
  reg_idx_t         ret_rd_idx_o;

  logic             empty_o;
  logic             full_o;

  modport master (
    output disp_valid_i, disp_longp_i, disp_rs1en_i, disp_rs2en_i, disp_rdwen_i,
           disp_rs1_idx_i, disp_rs2_idx_i, disp_rd_idx_i, ret_valid_i,
    input  disp_ready_o, alc_ptr_o, ret_ready_o, ret_ptr_o, ret_rdwen_o,
           ret_rd_idx_o, empty_o, full_o
  );

  modport slave (
    input  disp_valid_i, disp_longp_i, disp_rs1en_i, disp_rs2en_i, disp_rdwen_i,
           disp_rs1_idx_i, disp_rs2_idx_i, disp_rd_idx_i, ret_valid_i,
    output disp_ready_o, alc_ptr_o, ret_ready_o, ret_ptr_o, ret_rdwen_o,
           ret_rd_idx_o, empty_o, full_o
  );

endinterface

// File: rtl/exu_oitf_match.sv
// Compares one OITF entry against the dispatching instruction's operands.
// x0 never creates a dependency, so it is excluded from every match.
module exu_oitf_match
  import exu_oitf_pkg::*;
(
  input  oitf_entry_t entry_i,
  input  logic        rs1en_i,
  input  reg_idx_t    rs1_idx_i,
  input  logic        rs2en_i,
  input  reg_idx_t    rs2_idx_i,
  input  logic        rdwen_i,
  input  reg_idx_t    rd_idx_i,
  output logic        rs1_hit_o,
  output logic        rs2_hit_o,
  output logic        rd_hit_o
);

  logic live;

  assign live      = entry_i.valid & entry_i.rdwen;
  assign rs1_hit_o = live & rs1en_i & (rs1_idx_i != X0_IDX) & (rs1_idx_i == entry_i.rd_idx);
  assign rs2_hit_o = live & rs2en_i & (rs2_idx_i != X0_IDX) & (rs2_idx_i == entry_i.rd_idx);
  assign rd_hit_o  = live & rdwen_i & (rd_idx_i  != X0_IDX) & (rd_idx_i  == entry_i.rd_idx);

endmodule

// File: rtl/exu_oitf.sv
// Outstanding instruction track FIFO: allocates an entry per long-pipe
// dispatch, retires in order, and stalls dispatch on RAW/WAW against live entries.
module exu_oitf
  import exu_oitf_pkg::*;
#(
  parameter int OITF_DEPTH = OITF_DEPTH_DEF,
  parameter int PTR_W      = $clog2(OITF_DEPTH)
) (
  input logic       clk_i,
  input logic       rst_n_i,
  exu_oitf_if.slave oitf
);

  oitf_entry_t     entry_q [OITF_DEPTH];
  oitf_entry_t     entry_d [OITF_DEPTH];
  logic [PTR_W:0]  alc_ptr_q, alc_ptr_d;
  logic [PTR_W:0]  ret_ptr_q, ret_ptr_d;

  logic [PTR_W-1:0]      alc_idx, ret_idx;
  logic [OITF_DEPTH-1:0] rs1_hit, rs2_hit, rd_hit;
  logic                  empty, full, raw, waw, alloc, retire;

  assign alc_idx = alc_ptr_q[PTR_W-1:0];
  assign ret_idx = ret_ptr_q[PTR_W-1:0];
  assign empty   = (alc_ptr_q == ret_ptr_q);
  assign full    = (alc_idx == ret_idx) & (alc_ptr_q[PTR_W] != ret_ptr_q[PTR_W]);

  for (genvar gi = 0; gi < OITF_DEPTH; gi++) begin : g_match
    exu_oitf_match u_match (
      .entry_i   (entry_q[gi]),
      .rs1en_i   (oitf.disp_rs1en_i),
      .rs1_idx_i (oitf.disp_rs1_idx_i),
      .rs2en_i   (oitf.disp_rs2en_i),
      .rs2_idx_i (oitf.disp_rs2_idx_i),
      .rdwen_i   (oitf.disp_rdwen_i),
      .rd_idx_i  (oitf.disp_rd_idx_i),
      .rs1_hit_o (rs1_hit[gi]),
      .rs2_hit_o (rs2_hit[gi]),
      .rd_hit_o  (rd_hit[gi])
    );
  end

  // Hazards see pre-edge state only; a retire in the same cycle does not unblock.
  assign raw = (|rs1_hit) | (|rs2_hit);
  assign waw = |rd_hit;

  assign oitf.disp_ready_o = ~(raw | waw) & ~(oitf.disp_longp_i & full);
  assign alloc  = oitf.disp_valid_i & oitf.disp_ready_o & oitf.disp_longp_i;
  assign retire = oitf.ret_valid_i & ~empty;

  always_comb begin
    entry_d   = entry_q;
    alc_ptr_d = alc_ptr_q;
    ret_ptr_d = ret_ptr_q;
    if (retire) begin
      entry_d[ret_idx].valid = 1'b0;
      ret_ptr_d = ret_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (alloc) begin
      entry_d[alc_idx] = '{valid: 1'b1, rdwen: oitf.disp_rdwen_i, rd_idx: oitf.disp_rd_idx_i};
      alc_ptr_d = alc_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < OITF_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      alc_ptr_q <= '0;
      ret_ptr_q <= '0;
    end else begin
      entry_q   <= entry_d;
      alc_ptr_q <= alc_ptr_d;
      ret_ptr_q <= ret_ptr_d;
    end
  end

  // Retire fields are masked while empty so stale entries never appear.
  assign oitf.alc_ptr_o    = alc_idx;
  assign oitf.ret_ptr_o    = ret_idx;
  assign oitf.ret_ready_o  = ~empty;
  assign oitf.ret_rdwen_o  = ~empty & entry_q[ret_idx].rdwen;
  assign oitf.ret_rd_idx_o = empty ? X0_IDX : entry_q[ret_idx].rd_idx;
  assign oitf.empty_o      = empty;
  assign oitf.full_o       = full;

endmodule

// File: tb/tb_exu_oitf.sv
// Table-driven check of exu_oitf with a retire-order scoreboard.
module tb_exu_oitf;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;

  always #5 clk_i = ~clk_i;

  exu_oitf_if #(.PTR_W(2)) oitf ();

  exu_oitf #(.OITF_DEPTH(4), .PTR_W(2)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .oitf    (oitf)
  );

  typedef struct {
    logic       rst;
    logic       dv;
    logic       lp;
    logic       r1e;
    logic [4:0] r1;
    logic       r2e;
    logic [4:0] r2;
    logic       we;
    logic [4:0] rd;
    logic       rv;
    logic       rdy;
    logic       emp;
    logic       full;
    logic [1:0] alc;
    logic [1:0] ret;
  } vec_t;

  typedef struct {
    logic [1:0] ptr;
    logic       we;
    logic [4:0] rd;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rst, logic dv, logic lp, logic r1e, logic [4:0] r1,
                              logic r2e, logic [4:0] r2, logic we, logic [4:0] rd, logic rv,
                              logic rdy, logic emp, logic full, logic [1:0] alc, logic [1:0] ret);
    vec_t v;
    v.rst = rst; v.dv = dv; v.lp = lp; v.r1e = r1e; v.r1 = r1; v.r2e = r2e; v.r2 = r2;
    v.we = we; v.rd = rd; v.rv = rv; v.rdy = rdy; v.emp = emp; v.full = full;
    v.alc = alc; v.ret = ret;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    oitf.disp_valid_i   = v.dv;
    oitf.disp_longp_i   = v.lp;
    oitf.disp_rs1en_i   = v.r1e;
    oitf.disp_rs1_idx_i = v.r1;
    oitf.disp_rs2en_i   = v.r2e;
    oitf.disp_rs2_idx_i = v.r2;
    oitf.disp_rdwen_i   = v.we;
    oitf.disp_rd_idx_i  = v.rd;
    oitf.ret_valid_i    = v.rv;
  endtask

  initial begin
    sb_t e;
    //          rst dv lp r1e r1  r2e r2 we rd  rv   rdy emp full alc ret
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0,   1, 1, 0, 0, 0)); // 0 idle
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 5,  0,   1, 1, 0, 0, 0)); // 1 alloc rd5
    vecs.push_back(mk(0, 1, 0, 1, 5,  0, 0, 0, 0,  0,   0, 0, 0, 1, 0)); // 2 RAW rs1=5
    vecs.push_back(mk(0, 1, 0, 1, 5,  0, 0, 0, 0,  1,   0, 0, 0, 1, 0)); // 3 RAW + retire, no bypass
    vecs.push_back(mk(0, 1, 0, 1, 5,  0, 0, 0, 0,  0,   1, 1, 0, 1, 1)); // 4 cleared
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0,   1, 1, 0, 0, 0)); // 5 reset
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 1,  0,   1, 1, 0, 0, 0)); // 6 alloc rd1
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 2,  0,   1, 0, 0, 1, 0)); // 7 alloc rd2
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 3,  0,   1, 0, 0, 2, 0)); // 8 alloc rd3
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 4,  0,   1, 0, 0, 3, 0)); // 9 alloc rd4
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 6,  0,   0, 0, 1, 0, 0)); // 10 full stall
    vecs.push_back(mk(0, 1, 0, 1, 7,  0, 0, 0, 0,  0,   1, 0, 1, 0, 0)); // 11 non-long ok
    vecs.push_back(mk(0, 1, 0, 1, 3,  0, 0, 0, 0,  0,   0, 0, 1, 0, 0)); // 12 RAW rs1=3
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 4, 0, 0,  0,   0, 0, 1, 0, 0)); // 13 RAW rs2=4
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 1, 2,  0,   0, 0, 1, 0, 0)); // 14 WAW rd2
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 6,  1,   0, 0, 1, 0, 0)); // 15 full + retire
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 6,  0,   1, 0, 0, 0, 1)); // 16 accepted after wrap
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1,   1, 0, 1, 1, 1)); // 17 drain
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1,   1, 0, 0, 1, 2)); // 18 drain
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1,   1, 0, 0, 1, 3)); // 19 drain
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1,   1, 0, 0, 1, 0)); // 20 drain
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1,   1, 1, 0, 1, 1)); // 21 retire on empty
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0,   1, 1, 0, 1, 1)); // 22 unchanged
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 0,  0,   1, 1, 0, 1, 1)); // 23 alloc rd0
    vecs.push_back(mk(0, 1, 0, 1, 0,  0, 0, 1, 0,  0,   1, 0, 0, 2, 1)); // 24 x0 no hazard
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 9,  1,   1, 0, 0, 2, 1)); // 25 alloc + retire
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 0, 9,  0,   1, 0, 0, 3, 2)); // 26 alloc rdwen=0
    vecs.push_back(mk(0, 1, 0, 1, 9,  0, 0, 0, 0,  0,   0, 0, 0, 0, 2)); // 27 RAW rs1=9
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 1, 11, 0,   1, 0, 0, 0, 2)); // 28 alloc rd11
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0,   1, 1, 0, 0, 0)); // 29 reset with 3 entries
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1,   1, 1, 0, 0, 0)); // 30 no retire after reset

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk_i);
      drive(v);
      if (v.rst) begin
        rst_n_i = 1'b0;
        sb_q.delete();
      end
      #1;
      chk($sformatf("v%0d disp_ready", i), int'(oitf.disp_ready_o), int'(v.rdy));
      chk($sformatf("v%0d empty", i), int'(oitf.empty_o), int'(v.emp));
      chk($sformatf("v%0d full", i), int'(oitf.full_o), int'(v.full));
      chk($sformatf("v%0d ret_ready", i), int'(oitf.ret_ready_o), int'(!v.emp));
      chk($sformatf("v%0d alc_ptr", i), int'(oitf.alc_ptr_o), int'(v.alc));
      chk($sformatf("v%0d ret_ptr", i), int'(oitf.ret_ptr_o), int'(v.ret));
      if (v.emp) begin
        chk($sformatf("v%0d ret_rdwen idle", i), int'(oitf.ret_rdwen_o), 0);
        chk($sformatf("v%0d ret_rd_idx idle", i), int'(oitf.ret_rd_idx_o), 0);
      end
      if (v.rv && !v.emp) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d scoreboard underflow", i), 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("v%0d sb ret_ptr", i), int'(oitf.ret_ptr_o), int'(e.ptr));
          chk($sformatf("v%0d sb ret_rdwen", i), int'(oitf.ret_rdwen_o), int'(e.we));
          chk($sformatf("v%0d sb ret_rd_idx", i), int'(oitf.ret_rd_idx_o), int'(e.rd));
        end
      end
      if (v.dv && v.lp && v.rdy) begin
        e.ptr = v.alc;
        e.we  = v.we;
        e.rd  = v.rd;
        sb_q.push_back(e);
      end
      $display("vec %0d rst=%0d dv=%0d lp=%0d rv=%0d rdy=%0d empty=%0d full=%0d alc=%0d ret=%0d",
               i, v.rst, v.dv, v.lp, v.rv, oitf.disp_ready_o, oitf.empty_o, oitf.full_o,
               oitf.alc_ptr_o, oitf.ret_ptr_o);
      if (v.rst) begin
        @(negedge clk_i);
        chk($sformatf("v%0d held empty in reset", i), int'(oitf.empty_o), 1);
        rst_n_i = 1'b1;
      end
    end

    chk("scoreboard drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_oitf.md
EXU_OITF -- requirements
Module: exu_oitf

Interface
REQ-001 Parameter OITF_DEPTH, default 4, entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter PTR_W, default log2(OITF_DEPTH), entry tag width.
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 disp_valid_i  input  1  dispatch request from decode/issue.
REQ-006 disp_ready_o  output  1  dispatch accepted this cycle when high with disp_valid_i.
REQ-007 disp_longp_i  input  1  dispatched instruction is long-pipe and needs an entry.
REQ-008 disp_rs1en_i / disp_rs2en_i / disp_rdwen_i  input  1 each  operand read / rd write enables.
REQ-009 disp_rs1_idx_i / disp_rs2_idx_i / disp_rd_idx_i  input  5 each  register indices.
REQ-010 alc_ptr_o  output  PTR_W  tag of the entry allocated on the current handshake.
REQ-011 ret_valid_i  input  1  long-pipe writeback completes oldest entry.
REQ-012 ret_ready_o  output  1  retire accepted; equals ~empty_o.
REQ-013 ret_ptr_o  output  PTR_W  tag of oldest entry.
REQ-014 ret_rdwen_o / ret_rd_idx_o  output  1 / 5  rd enable and index of oldest entry.
REQ-015 empty_o / full_o  output  1 each  occupancy flags.

Function
REQ-016 Entries SHALL form an in-order FIFO; each entry holds valid, rdwen, rd_idx.
REQ-017 Pointers SHALL be PTR_W+1 bits (wrap bit); empty when equal, full when indices equal and wrap bits differ.
REQ-018 Allocation SHALL occur when disp_valid_i & disp_ready_o & disp_longp_i; entry at alc pointer is written on that edge, alc pointer increments.
REQ-019 Retire SHALL occur when ret_valid_i & ret_ready_o; oldest entry valid cleared, ret pointer increments.
REQ-020 RAW hazard: disp_rs1en_i with disp_rs1_idx_i != 0 matching rd_idx of any valid entry with rdwen set; likewise rs2.
REQ-021 WAW hazard: disp_rdwen_i with disp_rd_idx_i != 0 matching rd_idx of any valid entry with rdwen set.
REQ-022 disp_ready_o SHALL be ~(RAW | WAW) & ~(disp_longp_i & full_o), combinational from current state, no valid-to-ready dependency loop beyond disp_* fields.
REQ-023 Hazard check SHALL use pre-edge entry state; a same-cycle retire SHALL NOT bypass (conservative one-cycle stall).
REQ-024 Simultaneous alloc and retire SHALL both take effect; occupancy unchanged.
REQ-025 When full_o, a same-cycle retire SHALL NOT enable allocation that cycle.
REQ-026 ret_valid_i while empty_o SHALL be ignored; no state change.
REQ-027 Non-long-pipe dispatches SHALL only be hazard-checked, never allocate.
REQ-028 Pointer wrap from OITF_DEPTH-1 to 0 SHALL toggle the wrap bit.

Reset
REQ-029 On rst_n_i low, all entry valid bits and both pointers SHALL clear asynchronously.
REQ-030 Reset values: empty_o=1, full_o=0, ret_ready_o=0, alc_ptr_o=0, ret_ptr_o=0, ret_rdwen_o=0, ret_rd_idx_o=0; disp_ready_o follows REQ-022 with no hazards.
REQ-031 Reset mid-operation SHALL discard all outstanding entries; no retire is reported afterward.

Structure
REQ-032 Shared package SHALL hold OITF_DEPTH default, register index width (5) and x0 index constant.
REQ-033 Hazard match SHALL be a sub-module exu_oitf_match (one entry vs rs1/rs2/rd, outputs three hit bits), instanced OITF_DEPTH times.

Verification
REQ-034 Reset, alloc rd=5 long-pipe -> alc_ptr_o=0, empty_o=0; next dispatch rs1=5 -> disp_ready_o=0 until retire, then 1.
REQ-035 Four long-pipe allocs rd=1..4 -> full_o=1; fifth long-pipe disp_ready_o=0; non-long-pipe rs1=7 -> disp_ready_o=1.
REQ-036 Full, same cycle retire + long-pipe dispatch -> dispatch stalled; next cycle accepted, alc_ptr_o=0 with wrap toggled.
REQ-037 Entry rd=0 rdwen=1, dispatch rs1=0 rd=0 -> no hazard, disp_ready_o=1.
REQ-038 ret_valid_i on empty -> ret_ready_o=0, pointers unchanged; rst_n_i low with 3 entries -> empty_o=1 immediately.
